// File: rtl/cv32e40s_data_obi_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40s_data_obi_tracker
//  Brief    : Data-side OBI tracker between the LSU trans_*/resp_* handshake
//             and the external OBI data port. Holds the A-channel stable while
//             a request waits for grant, caps the number of outstanding
//             transactions, generates achk/reqpar, and checks rchk, gntpar and
//             rvalidpar.
//  Option   : CV32E40S_OBI_INTEGRITY_EN enables the rchk, gntpar and
//             rvalidpar checks. Without it only rvalid-with-nothing-outstanding
//             raises protocol_err_o. achk/reqpar generation is unconditional.
//  Revision : 1.0 - initial release
// ============================================================================

package cv32e40s_data_obi_tracker_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [2:0]  prot;
        logic [1:0]  memtype;
        logic        dbg;
    } obi_data_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        integrity_err;
    } obi_data_resp_t;

endpackage

module cv32e40s_data_obi_tracker
    import cv32e40s_data_obi_tracker_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 trans_valid_i,
    output logic                 trans_ready_o,
    input  obi_data_req_t        trans_i,

    output logic                 resp_valid_o,
    output obi_data_resp_t       resp_o,

    output logic                 obi_req_o,
    output logic                 obi_reqpar_o,
    input  logic                 obi_gnt_i,
    input  logic                 obi_gntpar_i,
    output logic [31:0]          obi_addr_o,
    output logic                 obi_we_o,
    output logic [3:0]           obi_be_o,
    output logic [31:0]          obi_wdata_o,
    output logic [2:0]           obi_prot_o,
    output logic [1:0]           obi_memtype_o,
    output logic                 obi_dbg_o,
    output logic [11:0]          obi_achk_o,
    input  logic                 obi_rvalid_i,
    input  logic                 obi_rvalidpar_i,
    input  logic [31:0]          obi_rdata_i,
    input  logic                 obi_err_i,
    input  logic [4:0]           obi_rchk_i,

    output logic [CNT_W-1:0]     outstanding_o,
    output logic                 protocol_err_o
);

    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    obi_data_req_t      r_hold;
    logic               r_protocol_err;

    logic               w_ready;
    logic               w_req;
    obi_data_req_t      w_a;
    logic               w_rvalid;
    logic               w_inc;
    logic               w_dec;
    logic               w_rvalid_zero;
    logic               w_integrity_err;
    logic               w_err_evt;

    // Handshake and A-channel selection. Outputs are gated by rst_n so the
    // port is quiet for the whole reset interval, not only after the edge.
    always_comb begin
        w_ready  = rst_n & (r_state == IDLE) & (r_count < c_MAX_CNT);
        w_req    = rst_n & ((r_state == WAIT_GNT) | (trans_valid_i & w_ready));
        w_a      = (r_state == WAIT_GNT) ? r_hold : trans_i;
        w_rvalid = rst_n & obi_rvalid_i;
    end

    // Counter events; a stray rvalid with nothing outstanding does not
    // decrement so the counter cannot wrap.
    always_comb begin
        w_inc         = w_req & obi_gnt_i;
        w_rvalid_zero = w_rvalid & (r_count == '0);
        w_dec         = w_rvalid & (r_count != '0);
    end

`ifdef CV32E40S_OBI_INTEGRITY_EN
    logic [4:0] w_rchk_exp;

    // Expected R-channel check bits and the resulting error events.
    always_comb begin
        w_rchk_exp      = {~^obi_err_i,
                           ~^obi_rdata_i[31:24], ~^obi_rdata_i[23:16],
                           ~^obi_rdata_i[15:8],  ~^obi_rdata_i[7:0]};
        w_integrity_err = w_rvalid & (obi_rchk_i != w_rchk_exp);
        w_err_evt       = (obi_gntpar_i == obi_gnt_i)
                        | (obi_rvalidpar_i == obi_rvalid_i)
                        | w_rvalid_zero
                        | w_integrity_err;
    end
`else
    logic w_unused_integrity;

    // Integrity checking is compiled out; only the count underflow is flagged.
    always_comb begin
        w_integrity_err    = 1'b0;
        w_err_evt          = w_rvalid_zero;
        w_unused_integrity = ^{obi_rchk_i, obi_gntpar_i, obi_rvalidpar_i};
    end
`endif

    // Output assembly: A-channel payload, check bits and the 0-latency response.
    always_comb begin
        trans_ready_o = w_ready;
        obi_req_o     = w_req;
        obi_reqpar_o  = ~w_req;
        obi_addr_o    = w_a.addr;
        obi_we_o      = w_a.we;
        obi_be_o      = w_a.be;
        obi_wdata_o   = w_a.wdata;
        obi_prot_o    = w_a.prot;
        obi_memtype_o = w_a.memtype;
        obi_dbg_o     = w_a.dbg;
        obi_achk_o    = {~^w_a.wdata[31:24], ~^w_a.wdata[23:16],
                         ~^w_a.wdata[15:8],  ~^w_a.wdata[7:0],
                         ~^6'b0,
                         ~^w_a.dbg,
                         ~^{w_a.be, w_a.we},
                         ~^{w_a.prot, w_a.memtype},
                         ~^w_a.addr[31:24],  ~^w_a.addr[23:16],
                         ~^w_a.addr[15:8],   ~^w_a.addr[7:0]};

        resp_valid_o         = w_rvalid;
        resp_o.rdata         = obi_rdata_i;
        resp_o.err           = obi_err_i;
        resp_o.integrity_err = w_integrity_err;

        outstanding_o  = r_count;
        protocol_err_o = r_protocol_err;
    end

    // Request FSM: park the payload in the holding register until granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hold  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && !obi_gnt_i) begin
                        r_hold  <= trans_i;
                        r_state <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (obi_gnt_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outstanding transaction counter; simultaneous grant and rvalid cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_inc && !w_dec) begin
            r_count <= r_count + c_ONE;
        end else if (w_dec && !w_inc) begin
            r_count <= r_count - c_ONE;
        end
    end

    // Sticky protocol/integrity error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_protocol_err <= 1'b0;
        end else if (w_err_evt) begin
            r_protocol_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40s_data_obi_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cv32e40s_data_obi_tracker
//  Brief    : Directed self-checking bench for cv32e40s_data_obi_tracker
//             (MAX_OUTSTANDING = 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40s_data_obi_tracker;
    import cv32e40s_data_obi_tracker_pkg::*;

`ifdef CV32E40S_OBI_INTEGRITY_EN
    localparam logic c_INTEG = 1'b1;
`else
    localparam logic c_INTEG = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           trans_valid_i;
    logic           trans_ready_o;
    obi_data_req_t  trans_i;
    logic           resp_valid_o;
    obi_data_resp_t resp_o;
    logic           obi_req_o;
    logic           obi_reqpar_o;
    logic           obi_gnt_i;
    logic           obi_gntpar_i;
    logic [31:0]    obi_addr_o;
    logic           obi_we_o;
    logic [3:0]     obi_be_o;
    logic [31:0]    obi_wdata_o;
    logic [2:0]     obi_prot_o;
    logic [1:0]     obi_memtype_o;
    logic           obi_dbg_o;
    logic [11:0]    obi_achk_o;
    logic           obi_rvalid_i;
    logic           obi_rvalidpar_i;
    logic [31:0]    obi_rdata_i;
    logic           obi_err_i;
    logic [4:0]     obi_rchk_i;
    logic [1:0]     outstanding_o;
    logic           protocol_err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cv32e40s_data_obi_tracker #(.MAX_OUTSTANDING(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .trans_valid_i   (trans_valid_i),
        .trans_ready_o   (trans_ready_o),
        .trans_i         (trans_i),
        .resp_valid_o    (resp_valid_o),
        .resp_o          (resp_o),
        .obi_req_o       (obi_req_o),
        .obi_reqpar_o    (obi_reqpar_o),
        .obi_gnt_i       (obi_gnt_i),
        .obi_gntpar_i    (obi_gntpar_i),
        .obi_addr_o      (obi_addr_o),
        .obi_we_o        (obi_we_o),
        .obi_be_o        (obi_be_o),
        .obi_wdata_o     (obi_wdata_o),
        .obi_prot_o      (obi_prot_o),
        .obi_memtype_o   (obi_memtype_o),
        .obi_dbg_o       (obi_dbg_o),
        .obi_achk_o      (obi_achk_o),
        .obi_rvalid_i    (obi_rvalid_i),
        .obi_rvalidpar_i (obi_rvalidpar_i),
        .obi_rdata_i     (obi_rdata_i),
        .obi_err_i       (obi_err_i),
        .obi_rchk_i      (obi_rchk_i),
        .outstanding_o   (outstanding_o),
        .protocol_err_o  (protocol_err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] achk_f(input obi_data_req_t t);
        return {~^t.wdata[31:24], ~^t.wdata[23:16], ~^t.wdata[15:8], ~^t.wdata[7:0],
                1'b1, ~^t.dbg, ~^{t.be, t.we}, ~^{t.prot, t.memtype},
                ~^t.addr[31:24], ~^t.addr[23:16], ~^t.addr[15:8], ~^t.addr[7:0]};
    endfunction

    function automatic logic [4:0] rchk_f(input logic [31:0] d, input logic e);
        return {~^e, ~^d[31:24], ~^d[23:16], ~^d[15:8], ~^d[7:0]};
    endfunction

    task automatic set_idle();
        trans_valid_i   = 1'b0;
        trans_i         = '0;
        obi_gnt_i       = 1'b0;
        obi_gntpar_i    = 1'b1;
        obi_rvalid_i    = 1'b0;
        obi_rvalidpar_i = 1'b1;
        obi_rdata_i     = '0;
        obi_err_i       = 1'b0;
        obi_rchk_i      = '0;
    endtask

    task automatic set_gnt(input logic g);
        obi_gnt_i    = g;
        obi_gntpar_i = ~g;
    endtask

    task automatic set_rvalid(input logic v, input logic [31:0] d, input logic [4:0] c);
        obi_rvalid_i    = v;
        obi_rvalidpar_i = ~v;
        obi_rdata_i     = d;
        obi_err_i       = 1'b0;
        obi_rchk_i      = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    obi_data_req_t t_a;
    obi_data_req_t t_b;
    obi_data_req_t t_c;

    initial begin
        // Reset with live inputs: outputs must stay quiet.
        rst_n = 1'b0;
        set_idle();
        trans_valid_i   = 1'b1;
        obi_rvalid_i    = 1'b1;
        obi_rvalidpar_i = 1'b0;
        #2;
        chk("rst_req",      obi_req_o,      1'b0);
        chk("rst_reqpar",   obi_reqpar_o,   1'b1);
        chk("rst_ready",    trans_ready_o,  1'b0);
        chk("rst_rvalid",   resp_valid_o,   1'b0);
        chk("rst_perr",     protocol_err_o, 1'b0);
        chk("rst_outst",    outstanding_o,  2'd0);
        step();
        set_idle();
        step();
        rst_n = 1'b1;
        #1;
        chk("idle_ready",   trans_ready_o,  1'b1);
        chk("idle_req",     obi_req_o,      1'b0);

        // Immediate grant.
        step();
        t_a = '0;
        t_a.addr = 32'h0000_1000;
        t_a.be   = 4'hF;
        trans_i = t_a;
        trans_valid_i = 1'b1;
        set_gnt(1'b1);
        #1;
        chk("ig_req",       obi_req_o,      1'b1);
        chk("ig_reqpar",    obi_reqpar_o,   1'b0);
        chk("ig_ready",     trans_ready_o,  1'b1);
        chk("ig_addr",      obi_addr_o,     32'h0000_1000);
        chk("ig_achk",      obi_achk_o,     achk_f(t_a));
        step();
        set_idle();
        #1;
        chk("ig_outst",     outstanding_o,  2'd1);
        chk("ig_ready2",    trans_ready_o,  1'b1);
        chk("ig_req2",      obi_req_o,      1'b0);

        // Grant stall: payload held for four cycles although trans_i changes.
        t_b = '0;
        t_b.addr  = 32'hDEAD_BEEC;
        t_b.wdata = 32'h1234_5678;
        t_b.we    = 1'b1;
        t_b.be    = 4'hF;
        t_b.prot  = 3'b101;
        t_b.dbg   = 1'b1;
        trans_i = t_b;
        trans_valid_i = 1'b1;
        #1;
        chk("gs1_req",      obi_req_o,      1'b1);
        chk("gs1_ready",    trans_ready_o,  1'b1);
        chk("gs1_addr",     obi_addr_o,     32'hDEAD_BEEC);
        chk("gs1_achk",     obi_achk_o,     achk_f(t_b));
        for (int c = 2; c <= 4; c++) begin
            step();
            trans_i = '0;
            if (c == 4) set_gnt(1'b1);
            #1;
            chk("gs_req",   obi_req_o,      1'b1);
            chk("gs_ready", trans_ready_o,  1'b0);
            chk("gs_addr",  obi_addr_o,     32'hDEAD_BEEC);
            chk("gs_wdata", obi_wdata_o,    32'h1234_5678);
            chk("gs_we",    obi_we_o,       1'b1);
            chk("gs_dbg",   obi_dbg_o,      1'b1);
            chk("gs_achk",  obi_achk_o,     achk_f(t_b));
        end
        step();
        set_idle();

        // Limit reached: two outstanding, no new request even with gnt high.
        t_c = '0;
        t_c.addr = 32'h0000_2000;
        trans_i = t_c;
        trans_valid_i = 1'b1;
        set_gnt(1'b1);
        #1;
        chk("lim_outst",    outstanding_o,  2'd2);
        chk("lim_ready",    trans_ready_o,  1'b0);
        chk("lim_req",      obi_req_o,      1'b0);
        chk("lim_reqpar",   obi_reqpar_o,   1'b1);
        step();
        chk("lim_outst2",   outstanding_o,  2'd2);
        set_idle();
        set_rvalid(1'b1, 32'hFF00_00FF, 5'b11111);
        #1;
        chk("rv_valid",     resp_valid_o,   1'b1);
        chk("rv_rdata",     resp_o.rdata,   32'hFF00_00FF);
        chk("rv_integ",     resp_o.integrity_err, 1'b0);
        step();
        set_idle();
        #1;
        chk("rv_outst",     outstanding_o,  2'd1);
        chk("rv_ready",     trans_ready_o,  1'b1);
        chk("rv_perr",      protocol_err_o, 1'b0);

        // Grant and rvalid together at count 1: count unchanged.
        trans_i = t_c;
        trans_valid_i = 1'b1;
        set_gnt(1'b1);
        set_rvalid(1'b1, 32'h1234_5678, rchk_f(32'h1234_5678, 1'b0));
        #1;
        chk("gr_req",       obi_req_o,      1'b1);
        step();
        set_idle();
        #1;
        chk("gr_outst",     outstanding_o,  2'd1);
        chk("gr_perr",      protocol_err_o, 1'b0);

        // Integrity: rchk[0] flipped.
        set_rvalid(1'b1, 32'hFF00_00FF, 5'b11110);
        #1;
        chk("ie_integ",     resp_o.integrity_err, c_INTEG);
        step();
        set_idle();
        #1;
        chk("ie_outst",     outstanding_o,  2'd0);
        chk("ie_perr",      protocol_err_o, c_INTEG);
        step();
        chk("ie_sticky",    protocol_err_o, c_INTEG);

        // Reset mid-operation: one outstanding plus one waiting for grant.
        trans_i = t_a;
        trans_valid_i = 1'b1;
        set_gnt(1'b1);
        step();
        trans_i = t_b;
        set_gnt(1'b0);
        step();
        #1;
        chk("rm_outst_pre", outstanding_o,  2'd1);
        chk("rm_wait",      trans_ready_o,  1'b0);
        rst_n = 1'b0;
        #1;
        chk("rm_req",       obi_req_o,      1'b0);
        chk("rm_outst",     outstanding_o,  2'd0);
        chk("rm_perr",      protocol_err_o, 1'b0);
        rst_n = 1'b1;
        trans_i = t_c;
        #1;
        chk("rm_idle_req",  obi_req_o,      1'b1);
        chk("rm_idle_rdy",  trans_ready_o,  1'b1);
        chk("rm_idle_addr", obi_addr_o,     32'h0000_2000);
        set_idle();
        step();

        // Protocol: rvalid with nothing outstanding.
        set_rvalid(1'b1, 32'hA5A5_A5A5, rchk_f(32'hA5A5_A5A5, 1'b0));
        #1;
        chk("pz_valid",     resp_valid_o,   1'b1);
        chk("pz_rdata",     resp_o.rdata,   32'hA5A5_A5A5);
        step();
        set_idle();
        #1;
        chk("pz_outst",     outstanding_o,  2'd0);
        chk("pz_perr",      protocol_err_o, 1'b1);

        // Grant parity mismatch.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        chk("gp_clear",     protocol_err_o, 1'b0);
        obi_gnt_i    = 1'b1;
        obi_gntpar_i = 1'b1;
        step();
        set_idle();
        #1;
        chk("gp_perr",      protocol_err_o, c_INTEG);
        chk("gp_outst",     outstanding_o,  2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
